// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-beat memory port between icache refills
// and dcache refills/writebacks; each granted line is split into LINE_WORDS word beats.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req_valid,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    output logic                  i_req_ready,
    output logic                  i_resp_valid,
    output logic [DATA_WIDTH-1:0] i_resp_data,
    output logic                  i_resp_last,
    input  logic                  d_req_valid,
    input  logic                  d_req_write,
    input  logic [ADDR_WIDTH-1:0] d_req_addr,
    output logic                  d_req_ready,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_wdata_ready,
    output logic                  d_resp_valid,
    output logic [DATA_WIDTH-1:0] d_resp_data,
    output logic                  d_resp_last,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int BEAT_W = $clog2(LINE_WORDS);
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK  = ADDR_WIDTH'(LINE_WORDS * 4 - 1);
    localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(LINE_WORDS - 1);
    localparam logic [BEAT_W-1:0]     BEAT_ONE  = BEAT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t                  state_r;
    logic [BEAT_W-1:0]       beat_r;
    logic [ADDR_WIDTH-1:0]   base_r;
    logic                    owner_d_r;
    logic                    write_r;
    logic                    last_grant_d_r;
    logic                    i_resp_valid_r;
    logic [DATA_WIDTH-1:0]   i_resp_data_r;
    logic                    i_resp_last_r;
    logic                    d_resp_valid_r;
    logic [DATA_WIDTH-1:0]   d_resp_data_r;
    logic                    d_resp_last_r;

    logic                    grant_i_s;
    logic                    grant_d_s;
    logic                    issue_s;
    logic                    is_last_s;
    logic [ADDR_WIDTH-1:0]   grant_base_s;
    logic [ADDR_WIDTH-1:0]   beat_addr_s;

    // Grant decision: only in IDLE and never while reset is held; ties go to the
    // requester that did not win last time.
    always_comb begin
        grant_i_s = 1'b0;
        grant_d_s = 1'b0;
        if (rst_n && (state_r == ST_IDLE)) begin
            if (i_req_valid && d_req_valid) begin
                if (last_grant_d_r) begin
                    grant_i_s = 1'b1;
                end else begin
                    grant_d_s = 1'b1;
                end
            end else begin
                grant_i_s = i_req_valid;
                grant_d_s = d_req_valid;
            end
        end else begin
            grant_i_s = 1'b0;
            grant_d_s = 1'b0;
        end
    end

    // Line base of the winning request and address/termination of the current beat.
    always_comb begin
        grant_base_s = {ADDR_WIDTH{1'b0}};
        if (grant_d_s) begin
            grant_base_s = d_req_addr & ~OFF_MASK;
        end else begin
            grant_base_s = i_req_addr & ~OFF_MASK;
        end
        beat_addr_s = base_r | ADDR_WIDTH'({beat_r, 2'b00});
        is_last_s   = (beat_r == LAST_BEAT);
        issue_s     = (state_r == ST_ISSUE);
    end

    // Transaction FSM with registered per-owner response beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            beat_r         <= {BEAT_W{1'b0}};
            base_r         <= {ADDR_WIDTH{1'b0}};
            owner_d_r      <= 1'b0;
            write_r        <= 1'b0;
            last_grant_d_r <= 1'b0;
            i_resp_valid_r <= 1'b0;
            i_resp_data_r  <= {DATA_WIDTH{1'b0}};
            i_resp_last_r  <= 1'b0;
            d_resp_valid_r <= 1'b0;
            d_resp_data_r  <= {DATA_WIDTH{1'b0}};
            d_resp_last_r  <= 1'b0;
        end else begin
            i_resp_valid_r <= 1'b0;
            i_resp_data_r  <= {DATA_WIDTH{1'b0}};
            i_resp_last_r  <= 1'b0;
            d_resp_valid_r <= 1'b0;
            d_resp_data_r  <= {DATA_WIDTH{1'b0}};
            d_resp_last_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (grant_i_s || grant_d_s) begin
                        owner_d_r      <= grant_d_s;
                        write_r        <= grant_d_s && d_req_write;
                        base_r         <= grant_base_s;
                        beat_r         <= {BEAT_W{1'b0}};
                        last_grant_d_r <= grant_d_s;
                        state_r        <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (mem_ready) begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_rvalid) begin
                        if (owner_d_r) begin
                            d_resp_valid_r <= 1'b1;
                            d_resp_data_r  <= write_r ? {DATA_WIDTH{1'b0}} : mem_rdata;
                            d_resp_last_r  <= is_last_s;
                        end else begin
                            i_resp_valid_r <= 1'b1;
                            i_resp_data_r  <= mem_rdata;
                            i_resp_last_r  <= is_last_s;
                        end
                        if (is_last_s) begin
                            beat_r  <= {BEAT_W{1'b0}};
                            state_r <= ST_IDLE;
                        end else begin
                            beat_r  <= beat_r + BEAT_ONE;
                            state_r <= ST_ISSUE;
                        end
                    end
                end
                default: begin
                    beat_r  <= {BEAT_W{1'b0}};
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign i_req_ready   = grant_i_s;
    assign d_req_ready   = grant_d_s;
    assign mem_valid     = issue_s;
    assign mem_write     = issue_s && write_r;
    assign mem_addr      = issue_s ? beat_addr_s : {ADDR_WIDTH{1'b0}};
    assign mem_wdata     = (issue_s && write_r) ? d_wdata : {DATA_WIDTH{1'b0}};
    assign d_wdata_ready = issue_s && write_r && mem_ready;
    assign i_resp_valid  = i_resp_valid_r;
    assign i_resp_data   = i_resp_data_r;
    assign i_resp_last   = i_resp_last_r;
    assign d_resp_valid  = d_resp_valid_r;
    assign d_resp_data   = d_resp_data_r;
    assign d_resp_last   = d_resp_last_r;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single backing-memory port between icache line refills and dcache line refills/writebacks. It arbitrates whole-line transactions round-robin and splits each granted line into LINE_WORDS single-word memory beats at incrementing addresses. It returns each beat to the owning cache. It sits between icache/dcache and the external memory model, below the fetch and memory pipeline stages.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, word width; must be 32 (beat stride 4 bytes)
- LINE_WORDS, 4, beats per line; power of two, 2..16
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- i_req_valid  in  1  icache line read request
- i_req_addr  in  ADDR_WIDTH  any byte address inside the line
- i_req_ready  out  1  request accepted this cycle
- i_resp_valid  out  1  one read beat valid
- i_resp_data  out  DATA_WIDTH  beat data
- i_resp_last  out  1  final beat of line
- d_req_valid  in  1  dcache line request
- d_req_write  in  1  1 = writeback, 0 = refill
- d_req_addr  in  ADDR_WIDTH  byte address inside the line
- d_req_ready  out  1  request accepted this cycle
- d_wdata  in  DATA_WIDTH  current writeback beat, held until d_wdata_ready
- d_wdata_ready  out  1  d_wdata consumed; advance to next beat
- d_resp_valid  out  1  beat done (read data or write ack)
- d_resp_data  out  DATA_WIDTH  read data; 0 for write acks
- d_resp_last  out  1  final beat of line
- mem_valid  out  1  beat request
- mem_ready  in  1  memory accepts beat
- mem_write  out  1  beat is a write
- mem_addr  out  ADDR_WIDTH  word-aligned beat address
- mem_wdata  out  DATA_WIDTH  write data (= d_wdata during write beats)
- mem_rvalid  in  1  read data / write ack for the outstanding beat
- mem_rdata  in  DATA_WIDTH  read data

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - If exactly one requester is valid, grant it.
  - If both are valid, grant the one not recorded in last_grant.
  - On grant: pulse x_req_ready (combinational, IDLE only), latch owner, write flag (icache always read), and base = addr with low log2(LINE_WORDS*4) bits cleared. Set beat = 0, update last_grant, go to ISSUE.
- ISSUE:
  - Drive mem_valid=1, mem_addr = base + 4*beat, and mem_write.
  - Hold all of these stable until mem_ready.
  - On a write beat, mem_wdata = d_wdata and d_wdata_ready = mem_valid && mem_ready.
  - On mem_ready, go to WAIT.
- WAIT:
  - mem_rvalid is only honoured in WAIT. Memory guarantees at least 1 cycle after acceptance.
  - On mem_rvalid, register the beat to the owner's resp_* (data for reads, 0 for writes). Set last = (beat == LINE_WORDS-1).
  - If last, go to IDLE; else increment beat and go to ISSUE.
- Non-owner resp_valid and non-owner x_req_ready stay 0 throughout a transaction.
- Requests arriving mid-transaction wait, and are not latched until IDLE.
- beat counter is log2(LINE_WORDS) bits. The address offset never carries out of the line.
- Reset (asynchronous, any state): state = IDLE, beat = 0, last_grant = icache (so dcache wins the first tie).
  - Every output is 0 during and after reset, until new activity.
  - An in-flight line is abandoned; its late mem_rvalid arrives in IDLE and is ignored.

## Timing
- Uncontended read, mem_ready held 1, mem_rvalid 1 cycle after acceptance:
  - cycle 0: req_valid, req_ready
  - cycle 1: ISSUE, mem_valid accepted
  - cycle 2: mem_rvalid
  - cycle 3: resp_valid for beat 0
- Each beat costs 2 cycles + memory stall; a 4-beat line has its last resp at cycle 9.
- resp_* are registered: one cycle after mem_rvalid, single-cycle pulses.
- The state is IDLE in the same cycle the last resp is driven, so back-to-back grants are possible.
- Minimum gap between the last beat's mem_rvalid and the next line's mem_valid is 2 cycles.
- mem_ready low stalls ISSUE indefinitely with outputs held.
- A request dropped before req_ready is never granted.

## Test plan
- icache read at 0x0000_1234, memory returns addr-as-data -> mem_addr 0x1230,0x1234,0x1238,0x123C; i_resp_data same sequence; i_resp_last only on 4th; first resp at cycle 3.
- Simultaneous i/d requests after reset, repeated 3 times -> grants D, I, D; no interleaving of beats between owners.
- dcache writeback to 0x80 with d_wdata 0xA0..0xA3 -> mem_write=1; mem_wdata A0,A1,A2,A3 at 0x80..0x8C; four d_wdata_ready pulses; d_resp_data 0; last on 4th.
- mem_ready held 0 for 5 cycles on beat 2 -> mem_valid/mem_addr 0x..8 stable; no extra d_wdata_ready; beat order preserved.
- rst_n asserted while in WAIT of beat 1 -> all outputs 0 immediately; next request starts at beat 0 with base re-latched; stale mem_rvalid produces no resp.
